decode_arbiter: RTL

Round-robin bus arbiter and access sequencer for a shared chip-select decoder. Up to NREQ requesters (CPU fetch, CPU load/store, DMA, debug) each ask for a device by 3-bit select code. The block grants one requester at a time and drives the decoder's select and enable pins through a fixed setup/strobe/hold sequence, then acknowledges. It sits between the bus masters and the address-decode chip on the shared peripheral bus.

---
 rtl/decode_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : decode_arbiter
//  Purpose  : Round-robin arbiter that grants one bus master at a time and
//             runs the shared chip-select decoder through a fixed
//             setup / strobe / hold sequence before acknowledging the owner.
//  Revision : 1.0  initial release
// ============================================================================
module decode_arbiter #(
  parameter int NREQ          = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [3*NREQ-1:0] sel_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   ack_o,
  output logic [2:0]        dec_s_o,
  output logic              dec_g1_o,
  output logic              dec_g2a_o,
  output logic              dec_g2b_o,
  output logic              busy_o
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NREQ - 1);
  localparam logic [IDX_W:0]   NREQ_W      = (IDX_W+1)'(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic [2:0]         dec_s_q, dec_s_d;
  logic               dec_g1_q, dec_g1_d;
  // A single flop feeds both active-low enables so they can never disagree.
  logic               dec_g2_q, dec_g2_d;
  logic               busy_q, busy_d;

  logic [2:0]         sel_arr [NREQ];
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;

  // Unpack the flat select bus into one 3-bit code per requester.
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_sel
      assign sel_arr[i] = sel_i[3*i +: 3];
    end
  endgenerate

  // Round-robin search: first requester at or after ptr, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!win_found && req_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; outputs default to the idle pattern.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    ack_d    = '0;
    dec_s_d  = dec_s_q;
    dec_g1_d = 1'b0;
    dec_g2_d = 1'b1;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_found) begin
          state_d          = SETUP;
          owner_d          = win_idx;
          grant_d[win_idx] = 1'b1;
          dec_s_d          = sel_arr[win_idx];
          dec_g1_d         = 1'b1;
          busy_d           = 1'b1;
        end
      end
      SETUP: begin
        state_d  = STROBE;
        cnt_d    = STROBE_LOAD;
        dec_g1_d = 1'b1;
        dec_g2_d = 1'b0;
        busy_d   = 1'b1;
      end
      STROBE: begin
        dec_g1_d = 1'b1;
        busy_d   = 1'b1;
        if (cnt_q == '0) begin
          state_d = HOLD;
          ack_d   = grant_q;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          dec_g2_d = 1'b0;
        end
      end
      HOLD: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      dec_s_q  <= '0;
      dec_g1_q <= 1'b0;
      dec_g2_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      dec_s_q  <= dec_s_d;
      dec_g1_q <= dec_g1_d;
      dec_g2_q <= dec_g2_d;
      busy_q   <= busy_d;
    end
  end

  assign grant_o   = grant_q;
  assign ack_o     = ack_q;
  assign dec_s_o   = dec_s_q;
  assign dec_g1_o  = dec_g1_q;
  assign dec_g2a_o = dec_g2_q;
  assign dec_g2b_o = dec_g2_q;
  assign busy_o    = busy_q;

endmodule
`default_nettype wire
